// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a shared, fixed-latency ALU.
// Optional ALU_ARB_OPCHECK_EN screens opcodes above 4'b1010 and answers them with resp_err.
module alu_arb #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req0_tr,
    input  logic [31:0] req0_sr,
    input  logic [31:0] req1_tr,
    input  logic [31:0] req1_sr,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_dr,
    output logic        resp_cf,
    output logic        resp_of,
    output logic        resp_err,
    output logic        busy,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_tr,
    output logic [31:0] alu_sr,
    input  logic [31:0] alu_dr,
    input  logic        alu_cf,
    input  logic        alu_of
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, ERR = 2'd2} state_t;

    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] tr_q, tr_d, sr_q, sr_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [31:0] resp_dr_q, resp_dr_d;
    logic        resp_cf_q, resp_cf_d;
    logic        resp_of_q, resp_of_d;
    logic        resp_err_q, resp_err_d;

    logic        grant_vld, grant_id, illegal_op, done;
    logic [3:0]  sel_op;
    logic [31:0] sel_tr, sel_sr;

    assign sel_op = grant_id ? req1_op : req0_op;
    assign sel_tr = grant_id ? req1_tr : req0_tr;
    assign sel_sr = grant_id ? req1_sr : req0_sr;
    assign done   = (state_q == EXEC) && (cnt_q == LAT_LAST);

`ifdef ALU_ARB_OPCHECK_EN
    assign illegal_op = sel_op > 4'b1010;
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = illegal_op ? ERR : EXEC;
            EXEC:    if (done) state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant only exists while IDLE; on a tie the requester not served last wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
        req0_ready = grant_vld && !grant_id;
        req1_ready = grant_vld && grant_id;
        busy       = (state_q != IDLE);
    end

    always_comb begin
        cnt_d        = 3'd0;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        tr_d         = tr_q;
        sr_d         = sr_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_dr_d    = resp_dr_q;
        resp_cf_d    = resp_cf_q;
        resp_of_d    = resp_of_q;
        resp_err_d   = resp_err_q;
        if (grant_vld) begin
            last_grant_d = grant_id;
            id_d         = grant_id;
            // Screened operations never reach the ALU, so its inputs keep their old values.
            if (!illegal_op) begin
                op_d = sel_op;
                tr_d = sel_tr;
                sr_d = sel_sr;
            end
        end
        if (state_q == EXEC) cnt_d = cnt_q + 3'd1;
        if (done) begin
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            resp_dr_d    = alu_dr;
            resp_cf_d    = alu_cf;
            resp_of_d    = alu_of;
            resp_err_d   = 1'b0;
        end else if (state_q == ERR) begin
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            resp_dr_d    = 32'd0;
            resp_cf_d    = 1'b0;
            resp_of_d    = 1'b0;
            resp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= 4'd0;
            tr_q         <= 32'd0;
            sr_q         <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_dr_q    <= 32'd0;
            resp_cf_q    <= 1'b0;
            resp_of_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            tr_q         <= tr_d;
            sr_q         <= sr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_dr_q    <= resp_dr_d;
            resp_cf_q    <= resp_cf_d;
            resp_of_q    <= resp_of_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign alu_op     = op_q;
    assign alu_tr     = tr_q;
    assign alu_sr     = sr_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_dr    = resp_dr_q;
    assign resp_cf    = resp_cf_q;
    assign resp_of    = resp_of_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: ALU_LAT, default 1, ALU pipeline latency in clk edges from operands driven to alu_dr/alu_cf/alu_of valid; legal range 1..7.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid, req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready, req1_ready  output  1 each  arbiter accepts requester N this cycle.
REQ-006 req0_op, req1_op  input  4 each  ALU opcode.
REQ-007 req0_tr, req0_sr, req1_tr, req1_sr  input  32 each  ALU operands.
REQ-008 resp_valid  output  1  one-cycle response strobe.
REQ-009 resp_id  output  1  requester the response belongs to.
REQ-010 resp_dr  output  32  result; resp_cf, resp_of  output  1 each  carry/overflow flags.
REQ-011 resp_err  output  1  illegal-opcode response.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 alu_op  output  4; alu_tr, alu_sr  output  32 each  operands to the shared alu instance.
REQ-014 alu_dr  input  32; alu_cf, alu_of  input  1 each  results from the shared alu.

Function
REQ-015 FSM states: IDLE, EXEC; optional ERR (REQ-032).
REQ-016 IDLE grant: only one valid -> that requester; both valid -> requester not granted last (round-robin); reqN_ready = IDLE && grant==N, combinational, never both high.
REQ-017 Transfer on reqN_valid && reqN_ready at edge E0: latch op/tr/sr and id, toggle last_grant to N, IDLE -> EXEC, latency counter cleared.
REQ-018 Requester holds valid and payload stable until ready; a dropped valid before ready is no request, no state change.
REQ-019 EXEC: alu_op/alu_tr/alu_sr driven from latched values, stable for whole EXEC; counter increments each edge.
REQ-020 EXEC lasts ALU_LAT+1 cycles; at edge E0+ALU_LAT+1 capture alu_dr/cf/of into resp_dr/cf/of, set resp_id, resp_err=0, resp_valid=1, EXEC -> IDLE.
REQ-021 resp_valid high exactly one cycle; resp_dr/cf/of/id hold until next response.
REQ-022 No response backpressure; requester must sample in resp_valid cycle.
REQ-023 Response cycle is IDLE: a new request may be accepted in the same cycle resp_valid is high.
REQ-024 Throughput: one operation per ALU_LAT+2 cycles with continuous requests.
REQ-025 Outside EXEC, alu_* hold last latched values (no spurious toggling).
REQ-026 Counter width 3 bits; no wrap within legal ALU_LAT.

Reset
REQ-027 rst high, any cycle including mid-EXEC: state IDLE, counter 0, in-flight operation discarded with no response.
REQ-028 Reset values: req0_ready/req1_ready follow IDLE rule (valid-dependent), resp_valid 0, resp_id 0, resp_dr 0, resp_cf 0, resp_of 0, resp_err 0, busy 0, alu_op 0, alu_tr 0, alu_sr 0.
REQ-029 Reset last_grant = 1 so requester 0 wins first simultaneous request.

Configuration
REQ-030 Macro ALU_ARB_OPCHECK_EN selects illegal-opcode screening; legal opcodes are 4'b0000..4'b1010.
REQ-031 Without ALU_ARB_OPCHECK_EN: all 16 opcodes go through EXEC; resp_err constant 0.
REQ-032 With ALU_ARB_OPCHECK_EN: accepted op > 4'b1010 -> ERR (not EXEC); alu_* unchanged; at E0+1 resp_valid=1, resp_err=1, resp_dr=0, resp_cf=0, resp_of=0, resp_id=requester; ERR -> IDLE; round-robin updated as normal.

Verification (bench alu stub: ALU_LAT=1, op 4'b0000 returns tr+sr)
REQ-033 req0 op=0000 tr=32 sr=21 accepted at E0 -> resp_valid at E0+2, resp_id=0, resp_dr=53, cf=0, of=0; busy high 2 cycles.
REQ-034 req0 and req1 valid same cycle after reset -> req0 granted first, req1 next; responses id 0 then id 1, 3 cycles apart.
REQ-035 req1 held continuously, req0 pulsed each IDLE -> grants alternate 0,1,0,1; neither starved.
REQ-036 rst pulsed one cycle mid-EXEC of tr=32 sr=21 -> no resp_valid for it; all outputs at reset values; next request served normally.
REQ-037 ALU_ARB_OPCHECK_EN defined, req0 op=4'b1100 -> resp_valid at E0+1, resp_err=1, resp_dr=0, alu_op unchanged; undefined -> normal EXEC path, resp_err=0.
REQ-038 op=0000 tr=32'hFFFFFFFF sr=1 -> resp_dr=0, resp_cf=1 passed through unchanged from alu.
